// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default sizing for the sequential multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);
endpackage

// File: rtl/mult_seq_if.sv
// mult_seq_if: operand/result handshake bundle between a producer/consumer and mult_seq
interface mult_seq_if import mult_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    modport master (
        output in_valid, mcand, mplier, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, mcand, mplier, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mult_step.sv
// mult_step: one combinational add-and-shift iteration of {acc, B} given multiplicand A
module mult_step import mult_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_b
);
    logic [WIDTH:0] w_sum;
    // add A into the upper half when B[0] is set, then shift {carry, acc, B} right by one
    always_comb begin
        w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, (i_b[0] ? i_a : {WIDTH{1'b0}})};
        o_acc = {w_sum, i_acc[WIDTH-1:1]};
        o_b   = {i_acc[0], i_b[WIDTH-1:1]};
    end
endmodule

// File: rtl/mult_seq.sv
// mult_seq: shift-and-add multiplier, one partial product per clock; MULT_SIGNED_EN selects two's-complement operands
module mult_seq import mult_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input logic       clk,
    input logic       reset,
    mult_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b, w_b, w_op_a, w_op_b;
    logic [2*WIDTH-1:0] r_acc, w_acc, r_product, w_result;
    logic [CW-1:0]      r_cnt;
    logic               w_accept, w_last;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    assign bus.product = r_product;

`ifdef MULT_SIGNED_EN
    logic r_sign;
    // magnitudes go into the unsigned core; the most negative value still fits in WIDTH bits
    assign w_op_a   = bus.mcand[WIDTH-1]  ? -bus.mcand  : bus.mcand;
    assign w_op_b   = bus.mplier[WIDTH-1] ? -bus.mplier : bus.mplier;
    assign w_result = r_sign ? -w_acc : w_acc;
    // result sign captured at accept, applied when the product is loaded
    always_ff @(posedge clk) begin
        if (reset)
            r_sign <= 1'b0;
        else if (w_accept)
            r_sign <= bus.mcand[WIDTH-1] ^ bus.mplier[WIDTH-1];
    end
`else
    assign w_op_a   = bus.mcand;
    assign w_op_b   = bus.mplier;
    assign w_result = w_acc;
`endif

    mult_step #(.WIDTH(WIDTH)) u_step (
        .i_a   (r_a),
        .i_acc (r_acc),
        .i_b   (r_b),
        .o_acc (w_acc),
        .o_b   (w_b)
    );

    // state register; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next state and handshake outputs decoded from the registered state only
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                w_next       = bus.in_valid ? RUN : IDLE;
            end
            RUN: begin
                bus.busy = 1'b1;
                w_next   = w_last ? DONE : RUN;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                w_next        = bus.out_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // operand latch, iteration and product load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= w_op_a;
            r_b   <= w_op_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_acc;
            r_b   <= w_b;
            r_cnt <= r_cnt + 1'b1;
            if (w_last)
                r_product <= w_result;
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vector table plus stall, reset and back-to-back sequences for mult_seq
module tb_mult_seq;
    import mult_pkg::*;
    localparam int W    = 8;
    localparam int NVEC = 6;
    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int n_run  = 0;
    int n_fail = 0;
    vec_t tbl [NVEC];
    logic [W-1:0] pa [5];
    logic [W-1:0] pb [5];
    int lat, k_acc, k_done, last, cyc;
    logic ok;

    mult_seq_if #(.WIDTH(W)) bus ();
    mult_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [2*W-1:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
`else
        logic [2*W-1:0] ua, ub;
        ua = a;
        ub = b;
        return ua * ub;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp, input string nm);
        int l, bsy;
        @(negedge clk);
        check({nm, " in_ready idle"}, 32'(bus.in_ready), 1);
        bus.mcand = a; bus.mplier = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mcand = ~a; bus.mplier = ~b;
        l = 0; bsy = 0;
        while (!bus.out_valid && l < 40) begin
            if (bus.busy) bsy++;
            @(negedge clk);
            l++;
        end
        check({nm, " latency"}, l, W);
        check({nm, " busy cycles"}, bsy, W);
        check({nm, " product"}, 32'(bus.product), 32'(exp));
        check({nm, " in_ready low in done"}, 32'(bus.in_ready), 0);
        @(negedge clk);
        check({nm, " out_valid dropped"}, 32'(bus.out_valid), 0);
        check({nm, " in_ready back"}, 32'(bus.in_ready), 1);
        check({nm, " product held"}, 32'(bus.product), 32'(exp));
    endtask

    initial begin
`ifdef MULT_SIGNED_EN
        tbl[0] = '{8'd13,  8'd11,  16'h008F};
        tbl[1] = '{8'h80,  8'h80,  16'h4000};
        tbl[2] = '{8'h80,  8'h7F,  16'hC080};
        tbl[3] = '{8'hFF,  8'h01,  16'hFFFF};
        tbl[4] = '{8'h7F,  8'h7F,  16'h3F01};
        tbl[5] = '{8'h00,  8'h85,  16'h0000};
`else
        tbl[0] = '{8'd13,  8'd11,  16'h008F};
        tbl[1] = '{8'd255, 8'd255, 16'hFE01};
        tbl[2] = '{8'd0,   8'd200, 16'h0000};
        tbl[3] = '{8'd255, 8'd1,   16'h00FF};
        tbl[4] = '{8'd128, 8'd2,   16'h0100};
        tbl[5] = '{8'd16,  8'd16,  16'h0100};
`endif
        bus.in_valid = 1'b0; bus.mcand = '0; bus.mplier = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 1);
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset product", 32'(bus.product), 0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));

        @(negedge clk);
        bus.mcand = 8'd7; bus.mplier = 8'd9; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("stall latency", lat, W);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0]; bus.mcand = 8'(i); bus.mplier = 8'(3 * i);
            @(negedge clk);
            if (bus.product !== 16'd63 || bus.out_valid !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
        end
        bus.in_valid = 1'b0;
        check("stall hold stable", 32'(ok), 1);
        check("stall product", 32'(bus.product), 63);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall handoff out_valid", 32'(bus.out_valid), 0);
        check("stall handoff in_ready", 32'(bus.in_ready), 1);
        check("stall handoff busy", 32'(bus.busy), 0);
        check("stall handoff product", 32'(bus.product), 63);

        @(negedge clk);
        bus.mcand = 8'd100; bus.mplier = 8'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun reset in_ready", 32'(bus.in_ready), 1);
        check("midrun reset out_valid", 32'(bus.out_valid), 0);
        check("midrun reset busy", 32'(bus.busy), 0);
        check("midrun reset product", 32'(bus.product), 0);
        reset = 1'b0;
        run_op(8'd2, 8'd3, 16'd6, "after reset");

        for (int i = 0; i < 5; i++) begin
            pa[i] = 8'($urandom_range(0, 255));
            pb[i] = 8'($urandom_range(0, 255));
        end
        k_acc = 0; k_done = 0; last = 0; cyc = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        while (k_done < 5 && cyc < 200) begin
            if (bus.out_valid) begin
                check($sformatf("b2b product %0d", k_done), 32'(bus.product), 32'(ref_mul(pa[k_done], pb[k_done])));
                k_done++;
            end
            if (bus.in_ready) begin
                if (k_acc < 5) begin
                    if (k_acc > 0) check($sformatf("b2b spacing %0d", k_acc), cyc - last, W + 2);
                    last = cyc;
                    bus.mcand = pa[k_acc]; bus.mplier = pb[k_acc]; bus.in_valid = 1'b1;
                    k_acc++;
                end else
                    bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("b2b results seen", k_done, 5);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
